// File: rtl/trace_capture.sv
// trace_capture: capture front end for the waveform graph.
// It samples a 2-bit state every (div+1) cycles into a circular buffer. The
// buffer is armed, searched for a trigger and then frozen, with the trigger
// sample at column D/2. The display side reads the frozen record one column
// per cycle as the scanner sweeps x, with a latency of two cycles.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sig_in[1:0]        sampled state (00 low, 01/10 high, 11 undefined)
//   div[15:0]          sample period minus 1, in clk cycles
//   arm                one-cycle pulse that starts or restarts a capture
//   trig_mode, trig_val  trigger select (00 imm, 01 change, 10 equal) and compare value
//   busy, done         capture running / frozen record available
//   x[10:0]            scanner column
//   state[1:0], change renderer inputs for the column presented 2 cycles earlier
module trace_capture #(
  parameter int          AW = 9,
  parameter logic [10:0] PX = 11'd10,
  parameter logic [10:0] BX = 11'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  sig_in,
  input  logic [15:0] div,
  input  logic        arm,
  input  logic [1:0]  trig_mode,
  input  logic [1:0]  trig_val,
  output logic        busy,
  output logic        done,
  input  logic [10:0] x,
  output logic [1:0]  state,
  output logic        change
);
  localparam int D = 1 << AW;
  localparam logic [AW-1:0] N_PRE_LAST  = AW'(D/2 - 1);
  localparam logic [AW-1:0] N_POST_LAST = AW'(D/2 - 2);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_HOLD} cap_st_t;

  cap_st_t       r_st, w_st_nxt;
  logic [15:0]   r_div_cnt;
  logic [AW-1:0] r_wr_ptr, r_start_ptr, r_n;
  logic [1:0]    r_last;
  logic          r_busy, r_done;
  logic [1:0]    r_mem [D];
  logic          w_tick, w_cap, w_we, w_trig, w_n_clr, w_latch_start;

  assign w_tick = (r_div_cnt == div);
  assign w_cap  = (r_st == S_PRE) || (r_st == S_WAIT) || (r_st == S_POST);
  // a restart wins over a coincident tick, so that tick is dropped
  assign w_we   = w_cap && w_tick && !arm;

  always_comb begin
    case (trig_mode)
      2'b01:   w_trig = (sig_in != r_last);
      2'b10:   w_trig = (sig_in == trig_val);
      default: w_trig = 1'b1;
    endcase
  end

  always_comb begin
    w_st_nxt      = r_st;
    w_n_clr       = 1'b0;
    w_latch_start = 1'b0;
    if (arm) begin
      w_st_nxt = S_PRE;
      w_n_clr  = 1'b1;
    end else if (w_we) begin
      case (r_st)
        S_PRE:   if (r_n == N_PRE_LAST) begin
                   w_st_nxt = S_WAIT;
                   w_n_clr  = 1'b1;
                 end
        S_WAIT:  if (w_trig) begin
                   w_st_nxt = S_POST;
                   w_n_clr  = 1'b1;
                 end
        S_POST:  if (r_n == N_POST_LAST) begin
                   w_st_nxt      = S_HOLD;
                   w_latch_start = 1'b1;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= S_IDLE;
      r_div_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_n         <= '0;
      r_last      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_busy <= (w_st_nxt == S_PRE) || (w_st_nxt == S_WAIT) || (w_st_nxt == S_POST);
      r_done <= (w_st_nxt == S_HOLD);
      if (arm || w_tick) r_div_cnt <= '0;
      else               r_div_cnt <= r_div_cnt + 16'd1;
      if (arm)       r_wr_ptr <= '0;
      else if (w_we) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_n_clr)   r_n <= '0;
      else if (w_we) r_n <= r_n + AW'(1);
      if (w_we) r_last <= sig_in;
      // the slot after the final write holds the oldest sample of the record
      if (w_latch_start) r_start_ptr <= r_wr_ptr + AW'(1);
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // ---------------- display path ----------------
  logic          w_vld, w_first;
  logic          r_v1, r_first1, r_v2, r_first2;
  logic [AW-1:0] r_raddr;
  logic [1:0]    r_rdata, r_prev;

  assign w_vld   = (x > PX) && (x < PX + BX);
  assign w_first = (x == PX + 11'd1);

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= sig_in;
    r_rdata <= r_mem[r_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_raddr  <= '0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_prev   <= '0;
    end else begin
      r_v1     <= w_vld;
      r_first1 <= w_first;
      r_raddr  <= r_start_ptr + AW'(x - PX - 11'd1);
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      if (r_v2) r_prev <= r_rdata;
    end
  end

  always_comb begin
    state  = 2'b00;
    change = 1'b0;
    if (r_v2) begin
      if (!r_done) begin
        state = 2'b11;
      end else begin
        state  = r_rdata;
        // a line start never reports a change against the previous line
        change = !r_first2 && (r_rdata != r_prev);
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;
  localparam int          AW   = 4;
  localparam int          D    = 16;
  localparam logic [10:0] PX   = 11'd10;
  localparam logic [10:0] BX   = 11'd17;
  localparam int          NCYC = 1200;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  sig_in = '0;
  logic [15:0] div = '0;
  logic        arm = 1'b0;
  logic [1:0]  trig_mode = '0, trig_val = '0;
  logic        busy, done;
  logic [10:0] x = '0;
  logic [1:0]  state;
  logic        change;

  trace_capture #(.AW(AW), .PX(PX), .BX(BX)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .div(div), .arm(arm),
    .trig_mode(trig_mode), .trig_val(trig_val), .busy(busy), .done(done),
    .x(x), .state(state), .change(change)
  );

  always #5 clk = ~clk;

  int          errs = 0, checks = 0;
  logic [1:0]  sig [NCYC];   // sig_in for each cycle after arm
  logic [1:0]  rec [D];      // expected frozen record, column 0 oldest
  logic [1:0]  m_prev = '0;  // last valid column data seen by the display
  logic [10:0] xq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind 0: 2-bit counter, 1: random with sparse changes, 2: 00 then 01 from cycle 20
  task automatic gen(input int kind);
    for (int j = 0; j < NCYC; j++) begin
      case (kind)
        0: sig[j] = 2'(j);
        2: sig[j] = (j >= 20) ? 2'b01 : 2'b00;
        default: sig[j] = (j == 0 || $urandom_range(0, 3) == 0) ? 2'($urandom) : sig[j-1];
      endcase
    end
  endtask

  // Samples are the values on tick cycles; the first D/2 fill the pre-trigger
  // half, the trigger is searched from sample D/2 on, and the record is the D
  // samples centred so that the trigger is column D/2.
  task automatic model(input int dv, input logic [1:0] md, input logic [1:0] tv, output int jdone);
    logic [1:0] s [$];
    int tj [$];
    int t;
    for (int j = 0; j < NCYC; j++)
      if (j % (dv + 1) == dv) begin
        s.push_back(sig[j]);
        tj.push_back(j);
      end
    t = -1;
    for (int i = D/2; i < s.size() && t < 0; i++) begin
      if (md == 2'b01) begin
        if (s[i] != s[i-1]) t = i;
      end else if (md == 2'b10) begin
        if (s[i] == tv) t = i;
      end else t = i;
    end
    jdone = -1;
    if (t >= 0 && t + D/2 - 1 < s.size()) begin
      jdone = tj[t + D/2 - 1];
      for (int c = 0; c < D; c++) rec[c] = s[t - D/2 + c];
    end
  endtask

  // drives xq one column per cycle; each column's outputs are checked 2 cycles later
  task automatic do_sweep();
    logic [1:0] es [$];
    logic       ec [$];
    for (int k = 0; k < xq.size(); k++) begin
      if (xq[k] > PX && xq[k] < PX + BX) begin
        int c;
        c = int'(xq[k] - PX - 11'd1);
        es.push_back(rec[c]);
        ec.push_back(c != 0 && rec[c] != m_prev);
        m_prev = rec[c];
      end else begin
        es.push_back(2'b00);
        ec.push_back(1'b0);
      end
    end
    for (int k = 0; k <= xq.size(); k++) begin
      x = (k < xq.size()) ? xq[k] : 11'd0;
      @(posedge clk); @(negedge clk);
      if (k >= 1) begin
        chk("disp_state", 32'(state), 32'(es[k-1]));
        chk("disp_change", 32'(change), 32'(ec[k-1]));
      end
    end
  endtask

  task automatic run_capture(input int dv, input logic [1:0] md, input logic [1:0] tv);
    int jd;
    model(dv, md, tv, jd);
    if (jd < 0) begin
      $display("note: stimulus had no trigger, capture skipped");
      return;
    end
    div = 16'(dv); trig_mode = md; trig_val = tv; x = PX + 11'd3;
    arm = 1'b1;
    @(posedge clk); @(negedge clk);
    arm = 1'b0;
    chk("busy_after_arm", 32'(busy), 32'd1);
    for (int j = 0; j < NCYC && j <= jd + 2; j++) begin
      sig_in = sig[j];
      @(posedge clk); @(negedge clk);
      chk("done", 32'(done), 32'(j >= jd));
      chk("busy", 32'(busy), 32'(j < jd));
      if (j == 2) chk("nodata_state", 32'(state), 32'd3);
    end
    xq.delete();
    for (int k = 0; k <= int'(PX + BX) + 2; k++) xq.push_back(11'(k));
    do_sweep();
    xq.delete();
    xq.push_back(PX + BX - 11'd1);   // last column then a line start
    xq.push_back(PX + 11'd1);
    for (int k = 0; k < 30; k++) xq.push_back(11'($urandom_range(0, int'(PX + BX) + 4)));
    do_sweep();
  endtask

  initial begin
    // reset with toggling input
    repeat (4) begin @(negedge clk); sig_in = 2'($urandom); end
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); sig_in = 2'($urandom); end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    gen(0); run_capture(0, 2'b00, 2'b00);   // immediate, done 16 cycles after busy
    gen(0); run_capture(3, 2'b00, 2'b00);   // decimation by 4
    gen(2); run_capture(0, 2'b01, 2'b00);   // change trigger at sample 20
    for (int r = 0; r < 6; r++) begin
      gen(1);
      run_capture(int'($urandom_range(0, 3)), 2'($urandom), 2'($urandom));
    end

    // re-arm while in POST: the new capture must run from scratch
    gen(0);
    div = 16'd0; trig_mode = 2'b00; x = PX + 11'd3;
    arm = 1'b1; @(posedge clk); @(negedge clk); arm = 1'b0;
    for (int j = 0; j < 12; j++) begin sig_in = sig[j]; @(posedge clk); @(negedge clk); end
    chk("post_busy", 32'(busy), 32'd1);
    chk("post_done", 32'(done), 32'd0);
    gen(1); run_capture(0, 2'b00, 2'b00);

    // async reset in the middle of WAIT
    for (int j = 0; j < NCYC; j++) sig[j] = 2'b00;
    div = 16'd0; trig_mode = 2'b10; trig_val = 2'b11; x = PX + 11'd3;
    arm = 1'b1; @(posedge clk); @(negedge clk); arm = 1'b0; sig_in = 2'b00;
    repeat (30) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_state", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_change", 32'(change), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
